// File: rtl/hamming_pkg.sv
// Shared constants and receiver state encoding for the Hamming(7,4) serial front end.
package hamming_pkg;

  localparam int CODE_WIDTH = 7;
  localparam int DATA_WIDTH = 4;
  localparam int BIT_IDX_W  = $clog2(CODE_WIDTH);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps on the full strobe.
// The clear input forces it back to zero.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic half_o,
  output logic full_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign half_o = (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
  assign full_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || full_o) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial receiver for 7-bit Hamming codewords (start, 7 bits MSB first, stop).
// Delivers each word through a one-entry valid/ready buffer and flags framing errors and overruns.
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  SerialIn,
  output logic [CODE_WIDTH-1:0] ReceivedHammingCode,
  output logic                  CodeValid,
  input  logic                  CodeReady,
  output logic                  FramingError,
  output logic                  Overrun
);

  logic [1:0]            sync_q;
  logic                  rx;
  rx_state_e             state_q, state_d;
  logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CODE_WIDTH-1:0] shift_q, shift_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic                  valid_q, valid_d;
  logic                  fe_q, fe_d;
  logic                  ov_q, ov_d;
  logic                  timer_clear, timer_half, timer_full;
  logic                  stop_sample;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .clear_i(timer_clear),
    .half_o (timer_half),
    .full_o (timer_full)
  );

  // Synchronizer resets to the idle-line level.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], SerialIn};
  end

  assign rx = sync_q[1];

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    timer_clear = 1'b0;
    stop_sample = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        timer_clear = 1'b1;
        if (rx) state_d = IDLE;
      end
      IDLE: begin
        timer_clear = 1'b1;
        if (!rx) state_d = START;
      end
      START: begin
        if (timer_half) begin
          timer_clear = 1'b1;
          if (rx) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (timer_full) begin
          shift_d = {shift_q[CODE_WIDTH-2:0], rx};
          if (bit_idx_q == BIT_IDX_W'(CODE_WIDTH - 1)) state_d = STOP;
          else                                         bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_full) begin
          stop_sample = 1'b1;
          state_d     = rx ? IDLE : WAIT_IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // Accept and deliver may coincide: the pop clears valid, the push then sets it again.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    if (valid_q && CodeReady) valid_d = 1'b0;
    if (stop_sample) begin
      if (!rx) begin
        fe_d = 1'b1;
      end else if (!valid_q || CodeReady) begin
        code_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= WAIT_IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign ReceivedHammingCode = code_q;
  assign CodeValid           = valid_q;
  assign FramingError        = fe_q;
  assign Overrun             = ov_q;

endmodule
